// File: rtl/ahb_lite_rtl_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM slave: bus encodings,
// the slave FSM state set and the byte-lane strobe decoder.
package ahb_lite_rtl_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    localparam int MAX_LANES = 8;

    // Byte enables for an access of 2^hsize bytes starting at lane addr_lsb.
    // Only lanes that exist on a data_w-bit bus take part in the shift.
    function automatic logic [MAX_LANES-1:0] size_to_strobe(
        input logic [2:0] addr_lsb,
        input logic [2:0] hsize,
        input int         data_w
    );
        logic [7:0] base_s;
        logic [2:0] lane_s;
        if (data_w == 64) begin
            lane_s = addr_lsb;
        end else begin
            lane_s = {1'b0, addr_lsb[1:0]};
        end
        case (hsize)
            3'd0:    base_s = 8'h01;
            3'd1:    base_s = 8'h03;
            3'd2:    base_s = 8'h0F;
            3'd3:    base_s = 8'hFF;
            default: base_s = 8'h00;
        endcase
        return base_s << lane_s;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised storage: one byte-enabled synchronous write port and one
// asynchronous read port sharing a single word index. Contents are not reset.
module ahb_sram_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Commit the enabled byte lanes of the write word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of an internal SRAM: address decode and error
// detection, the response FSM with programmable wait states, and the
// registered handshake outputs.
module ahb_lite_sram_slave
    import ahb_lite_rtl_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int                NB        = DATA_W / 8;
    localparam int                LANE_W    = $clog2(NB);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W+1)'(DEPTH * NB);
    localparam bit                HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0]        WS_LOAD   = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    state_e              state_r, state_nxt_s;
    logic [2:0]          cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]    idx_r;
    logic [2:0]          lane_r;
    logic [2:0]          size_r;
    logic                write_r;
    logic                hreadyout_r, hresp_r;
    logic                ready_nxt_s, resp_nxt_s;

    logic [ADDR_W-1:0]   offset_s;
    logic                align_err_s, size_err_s, range_err_s, err_s;
    logic                ready_state_s, accept_s;
    logic [MAX_LANES-1:0] strobe_full_s;
    logic                we_s;
    logic [DATA_W-1:0]   rdata_s;
    logic                unused_s;

    assign offset_s      = HADDR - BASE_ADDR;
    assign range_err_s   = ({1'b0, offset_s} >= MEM_BYTES);
    assign size_err_s    = (HSIZE > 3'(LANE_W));
    assign err_s         = range_err_s | align_err_s | size_err_s;
    assign ready_state_s = (state_r == ST_IDLE) || (state_r == ST_DATA) || (state_r == ST_ERR2);
    assign accept_s      = HSEL & HREADY & HTRANS[1] & ready_state_s;

    // Address must be a multiple of the transfer size.
    always_comb begin
        case (HSIZE)
            3'd0:    align_err_s = 1'b0;
            3'd1:    align_err_s = HADDR[0];
            3'd2:    align_err_s = |HADDR[1:0];
            3'd3:    align_err_s = |HADDR[2:0];
            default: align_err_s = 1'b1;
        endcase
    end

    // Next state, wait counter and the handshake values for the next cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nxt_s = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WS_LOAD;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
        ready_nxt_s = !((state_nxt_s == ST_WAIT) || (state_nxt_s == ST_ERR1));
        resp_nxt_s  = (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
    end

    // FSM state, wait counter and registered handshake outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hreadyout_r <= ready_nxt_s;
            hresp_r     <= resp_nxt_s;
        end
    end

    // Capture the address-phase controls of each accepted transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_r   <= '0;
            lane_r  <= 3'd0;
            size_r  <= 3'd0;
            write_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= offset_s[LANE_W +: IDX_W];
            lane_r  <= offset_s[2:0];
            size_r  <= HSIZE;
            write_r <= HWRITE;
        end
    end

    // Errored transfers never reach DATA, so they can never write.
    assign strobe_full_s = size_to_strobe(lane_r, size_r, DATA_W);
    assign we_s          = (state_r == ST_DATA) && write_r;

    ahb_sram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (HCLK),
        .we    (we_s),
        .be    (strobe_full_s[NB-1:0]),
        .addr  (idx_r),
        .wdata (HWDATA),
        .rdata (rdata_s)
    );

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = (state_r == ST_DATA) ? rdata_s : '0;

    assign unused_s = ^{HBURST, HTRANS[0], strobe_full_s};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: one instance with no wait states and one
// with three, each checked cycle by cycle against a transfer-level model.
module tb_ahb_lite_sram_slave;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    typedef struct {
        logic [1:0]  trans;
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        hand;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } op_t;

    logic        hclk;
    logic        rst_n     [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    logic [31:0] ref_mem [2][DEPTH];
    op_t         ops [$];
    int          errors = 0;
    int          checks = 0;

    ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
        .HCLK(hclk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

    ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut1 (
        .HCLK(hclk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: decide error/read data and update the memory image.
    task automatic model_apply(input int d, input op_t o, output op_t r);
        logic [31:0] off;
        int          nbytes;
        logic        err;
        int          w;
        r = o;
        if (o.sel && o.trans[1]) begin
            off    = o.addr - BASE;
            nbytes = 1 << o.size;
            err    = (off >= DEPTH * 4) || ((o.addr & 32'(nbytes - 1)) != 32'd0) || (nbytes > 4);
            if (!o.hand) r.exp_err = err;
            if (!err) begin
                w = int'(off / 4);
                if (o.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (b >= int'(off % 4) && b < int'(off % 4) + nbytes)
                            ref_mem[d][w][8*b +: 8] = o.wdata[8*b +: 8];
                end else if (!o.hand) begin
                    r.exp_rdata = ref_mem[d][w];
                end
            end
        end
    endtask

    task automatic add(input int d, input logic [1:0] trans, input logic sel, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                       input logic hand, input logic exp_err, input logic [31:0] exp_rdata);
        op_t o, r;
        o.trans = trans; o.sel = sel; o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
        o.hand = hand; o.exp_err = exp_err; o.exp_rdata = exp_rdata;
        model_apply(d, o, r);
        ops.push_back(r);
    endtask

    task automatic bus_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'd0; hwrite[d] = 1'b0; haddr[d] = 32'd0;
        hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = 32'd0;
    endtask

    // Drive the queued ops as a pipelined master and check every cycle.
    task automatic run(input int d);
        int  ws     = (d == 0) ? 0 : 3;
        int  n      = ops.size();
        int  budget = n * (ws + 3) + 20;
        int  i      = 0;
        int  phase  = 0;
        int  cyc    = 0;
        bit  pend   = 1'b0;
        bit  fin, exp_ready, exp_resp;
        op_t p;
        while ((i < n || pend) && cyc < budget) begin
            if (i < n) begin
                hsel[d] = ops[i].sel; htrans[d] = ops[i].trans; hwrite[d] = ops[i].wr;
                haddr[d] = ops[i].addr; hsize[d] = ops[i].size; hburst[d] = 3'($urandom_range(0, 7));
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'd0;
            end
            hwdata[d] = pend ? p.wdata : $urandom;
            @(negedge hclk);
            if (pend) begin
                fin       = p.exp_err ? (phase == 1) : (phase == ws);
                exp_ready = fin;
                exp_resp  = p.exp_err;
                if (fin && !p.exp_err && !p.wr) chk("rdata", hrdata[d], p.exp_rdata);
                else if (!(fin && !p.exp_err))  chk("rdata_zero", hrdata[d], 32'd0);
            end else begin
                exp_ready = 1'b1;
                exp_resp  = 1'b0;
                chk("rdata_idle", hrdata[d], 32'd0);
            end
            chk("hreadyout", {31'd0, hreadyout[d]}, {31'd0, exp_ready});
            chk("hresp", {31'd0, hresp[d]}, {31'd0, exp_resp});
            @(posedge hclk); #1;
            if (exp_ready) begin
                pend = 1'b0;
                if (i < n) begin
                    if (ops[i].sel && ops[i].trans[1]) begin
                        p = ops[i]; pend = 1'b1; phase = 0;
                    end
                    i++;
                end
            end else begin
                phase++;
            end
            cyc++;
        end
        if (cyc >= budget) chk("timeout", 32'(cyc), 32'(budget - 1));
        bus_idle(d);
        ops.delete();
    endtask

    task automatic random_ops(input int d, input int count);
        for (int k = 0; k < count; k++) begin
            int          kind = $urandom_range(0, 9);
            int          r    = $urandom_range(0, 19);
            logic [2:0]  sz   = 3'($urandom_range(0, 2));
            logic [31:0] a;
            a = BASE + (32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1));
            if (r == 0) a = BASE + 32'd1024 + 32'($urandom_range(0, 63) * 4);
            else if (r == 1) a = BASE + 32'($urandom_range(0, 255));
            else if (r == 2) sz = 3'd3;
            if (kind == 0)      add(d, 2'd0, 1'b1, 1'b0, a, sz, $urandom, 1'b0, 1'b0, 32'd0);
            else if (kind == 1) add(d, 2'd1, 1'b1, 1'b0, a, sz, $urandom, 1'b0, 1'b0, 32'd0);
            else if (kind == 2) add(d, 2'($urandom_range(0, 3)), 1'b0, 1'($urandom), a, sz, $urandom, 1'b0, 1'b0, 32'd0);
            else add(d, 2'($urandom_range(2, 3)), 1'b1, 1'($urandom), a, sz, $urandom, 1'b0, 1'b0, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] old_word;
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            rst_n[d] = 1'b0;
        end
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_hreadyout", {31'd0, hreadyout[d]}, 32'd1);
            chk("reset_hresp", {31'd0, hresp[d]}, 32'd0);
            chk("reset_hrdata", hrdata[d], 32'd0);
            rst_n[d] = 1'b1;
        end
        @(posedge hclk); #1;

        // Give both memories a known image over the region the tests use.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++)
                add(d, 2'd2, 1'b1, 1'b1, BASE + 32'(w * 4), 3'd2, $urandom, 1'b0, 1'b0, 32'd0);
            run(d);
        end

        // Zero-wait directed table: write/read turnaround, byte lanes, IDLE/BUSY gaps.
        add(0, 2'd2, 1'b1, 1'b1, BASE + 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        add(0, 2'd2, 1'b1, 1'b0, BASE + 32'h10, 3'd2, 32'd0,        1'b1, 1'b0, 32'hDEADBEEF);
        add(0, 2'd2, 1'b1, 1'b1, BASE + 32'h20, 3'd0, 32'h11111111, 1'b0, 1'b0, 32'd0);
        add(0, 2'd3, 1'b1, 1'b1, BASE + 32'h21, 3'd0, 32'h22222222, 1'b0, 1'b0, 32'd0);
        add(0, 2'd3, 1'b1, 1'b1, BASE + 32'h22, 3'd0, 32'h33333333, 1'b0, 1'b0, 32'd0);
        add(0, 2'd3, 1'b1, 1'b1, BASE + 32'h23, 3'd0, 32'h44444444, 1'b0, 1'b0, 32'd0);
        add(0, 2'd2, 1'b1, 1'b0, BASE + 32'h20, 3'd2, 32'd0,        1'b1, 1'b0, 32'h44332211);
        add(0, 2'd2, 1'b1, 1'b1, BASE + 32'h16, 3'd1, 32'hCAFE0000, 1'b0, 1'b0, 32'd0);
        add(0, 2'd2, 1'b1, 1'b0, BASE + 32'h10, 3'd2, 32'd0,        1'b1, 1'b0, 32'hDEADBEEF);
        add(0, 2'd1, 1'b1, 1'b0, BASE + 32'h14, 3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        add(0, 2'd3, 1'b1, 1'b0, BASE + 32'h14, 3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        add(0, 2'd0, 1'b1, 1'b0, BASE + 32'h18, 3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        add(0, 2'd3, 1'b1, 1'b0, BASE + 32'h20, 3'd2, 32'd0,        1'b1, 1'b0, 32'h44332211);
        add(0, 2'd2, 1'b1, 1'b1, BASE + 32'h02, 3'd2, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0);
        add(0, 2'd2, 1'b1, 1'b0, BASE + 32'h00, 3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        run(0);

        // Three-wait directed table: OKAY read, range/alignment/size errors, cancel in ERR2.
        add(1, 2'd2, 1'b1, 1'b0, BASE + 32'h10,  3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        add(1, 2'd2, 1'b1, 1'b0, BASE + 32'd1024, 3'd2, 32'd0,       1'b1, 1'b1, 32'd0);
        add(1, 2'd2, 1'b1, 1'b1, BASE + 32'h02,  3'd2, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0);
        add(1, 2'd0, 1'b1, 1'b0, BASE + 32'h00,  3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        add(1, 2'd2, 1'b1, 1'b0, BASE + 32'h00,  3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        add(1, 2'd2, 1'b1, 1'b1, BASE + 32'h08,  3'd3, 32'h12345678, 1'b1, 1'b1, 32'd0);
        add(1, 2'd2, 1'b1, 1'b0, BASE - 32'd4,   3'd2, 32'd0,        1'b1, 1'b1, 32'd0);
        add(1, 2'd2, 1'b1, 1'b0, BASE + 32'h08,  3'd2, 32'd0,        1'b0, 1'b0, 32'd0);
        run(1);

        // Reset during the wait states of a write: outputs snap back, memory untouched.
        old_word = ref_mem[1][16];
        hsel[1] = 1'b1; htrans[1] = 2'd2; hwrite[1] = 1'b1; haddr[1] = BASE + 32'h40; hsize[1] = 3'd2;
        @(posedge hclk); #1;
        htrans[1] = 2'd0; hsel[1] = 1'b0; hwdata[1] = ~old_word;
        @(negedge hclk);
        chk("wait_before_reset", {31'd0, hreadyout[1]}, 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("async_reset_hreadyout", {31'd0, hreadyout[1]}, 32'd1);
        chk("async_reset_hresp", {31'd0, hresp[1]}, 32'd0);
        chk("async_reset_hrdata", hrdata[1], 32'd0);
        @(posedge hclk); #1;
        rst_n[1] = 1'b1;
        bus_idle(1);
        @(posedge hclk); #1;
        add(1, 2'd2, 1'b1, 1'b0, BASE + 32'h40, 3'd2, 32'd0, 1'b1, 1'b0, old_word);
        run(1);

        // Randomised traffic against the model on both configurations.
        for (int d = 0; d < 2; d++) begin
            random_ops(d, 150);
            run(d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Parametrised AHB-Lite slave backed by an internal word-organised SRAM. It is the synthesizable DUT that the AHB-Lite verification environment drives. It generalises a fixed zero-wait memory model in three ways: configurable data width, depth and wait states; byte, halfword and word writes through byte lanes; and a two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, bus data width; legal values 32 or 64
- DEPTH, 1024, number of DATA_W-bit words
- WAIT_STATES, 0, HREADYOUT low cycles per OKAY data phase; range 0..7
- BASE_ADDR, 0, byte address of word 0; must be aligned to DEPTH*DATA_W/8

Ports:
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous and active-low
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, log2 bytes
- HBURST  in  3  accepted, ignored; each beat is decoded independently
- HWDATA  in  DATA_W  write data, valid in the data phase
- HREADY  in  1  bus-level ready; qualifies the address phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_W  read data

## Operation
- A transfer is accepted on an edge where HSEL & HREADY & HTRANS[1] is true. At that edge, register the address, write flag, size and error flag.
- IDLE or BUSY with HSEL, or any cycle without HSEL: no transfer. The next cycle is OKAY with HREADYOUT=1.
- The error flag is set if any of the following holds:
  - HADDR-BASE_ADDR >= DEPTH*DATA_W/8
  - HADDR is misaligned to HSIZE
  - 2^HSIZE > DATA_W/8
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted OKAY transfer -> WAIT if WAIT_STATES>0, else DATA. Accepted error transfer -> ERR1.
  - WAIT: HREADYOUT=0. The counter loads WAIT_STATES-1 and decrements. At zero -> DATA.
  - DATA: HREADYOUT=1, HRESP=0, transfer completes. A new accepted transfer in the same cycle -> WAIT, DATA or ERR1 as from IDLE. Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, then -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. The master may cancel by driving HTRANS=IDLE. Otherwise a new accepted transfer branches as from IDLE.
- Writes:
  - Byte strobes come from the registered HADDR low bits and HSIZE.
  - The strobed lanes of HWDATA are committed on the edge that ends DATA.
  - Errored writes never modify memory.
- Reads:
  - The array is read asynchronously at the registered word index.
  - HRDATA shows the full word during DATA and is 0 in every other state.
  - The master extracts narrow data by lane.
- A write immediately followed by a read of the same word returns the new data. This needs no forwarding because the commit edge precedes the read data phase.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0.
- Reset asserted mid-transfer aborts the transfer, with no memory write. Outputs return to their reset values asynchronously.
- Read latency: data is valid WAIT_STATES+1 cycles after the address-phase edge.
- Write commit happens on the edge WAIT_STATES+1 cycles after the address-phase edge.
- Pipelining: with WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers complete one per cycle.
- The ERROR response is always 2 cycles, independent of WAIT_STATES.
- An address phase presented while HREADYOUT=0 is not sampled because HREADY=0. The master holds it.

## Structure
- Package ahb_lite_rtl_pkg holds:
  - htrans_e, hresp_e and the FSM state enum {IDLE, WAIT, DATA, ERR1, ERR2}
  - the function size_to_strobe(addr_lsb, hsize, DATA_W)
- Sub-module ahb_sram_array holds the storage:
  - DEPTH x DATA_W
  - one write port with a per-byte enable
  - one asynchronous read port
- ahb_lite_sram_slave contains the decode, the FSM, the wait counter and the output registers.

## Test plan
- Reset, then WAIT_STATES=0: write 32'hDEADBEEF to offset 0x10, then read 0x10 back-to-back. Expect HRDATA=32'hDEADBEEF in the next cycle and zero wait cycles.
- HSIZE=0 byte writes of 0x11, 0x22, 0x33, 0x44 to offsets 0x20..0x23. A word read of 0x20 must return 32'h44332211.
- WAIT_STATES=3: read. Expect HREADYOUT low for exactly 3 cycles, then data with HRESP=0.
- Read at offset DEPTH*4, then a word write at 0x2. Each gets HRESP=1 for 2 cycles with HREADYOUT 0 then 1, and memory is unchanged.
- Assert HRESETn during the WAIT state of a write to 0x40. The outputs reach reset values immediately, and a later read of 0x40 shows the old data.
- IDLE and BUSY with HSEL=1 interleaved with SEQ reads: IDLE/BUSY cycles give HREADYOUT=1, HRESP=0, and the SEQ data is correct.
